// File: rtl/fc_layer_pkg.sv
// Shared types and address-map helpers for the fully-connected classifier stage.
package fc_layer_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN1 = 2'd1,
    DRAIN2 = 2'd2,
    OUT    = 2'd3
  } state_t;

  // Weight rows are packed class-major; biases follow all weight rows.
  function automatic int weight_base(input int cls, input int num_inputs);
    return cls * num_inputs;
  endfunction

  function automatic int bias_base(input int num_classes, input int num_inputs);
    return num_classes * num_inputs;
  endfunction

  function automatic int addr_width(input int num_classes, input int num_inputs);
    int words;
    words = num_classes * (num_inputs + 1);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int idx_width(input int num_inputs);
    return (num_inputs > 1) ? $clog2(num_inputs) : 1;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// One class lane: registered signed multiply followed by a wrapping accumulator.
module fc_mac #(
  parameter int BW        = 8,
  parameter int OUTPUT_BW = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mul_en,
  input  logic                        acc_en,
  input  logic                        clear,
  input  logic signed [BW-1:0]        data,
  input  logic signed [BW-1:0]        weight,
  output logic signed [OUTPUT_BW-1:0] acc
);

  logic signed [2*BW-1:0] prod;

  // NOTE: state is updated with <= so every register samples pre-edge values,
  // keeping the multiply and accumulate stages a true two-stage pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mul_en) prod <= (2*BW)'(data) * (2*BW)'(weight);
      if (clear)       acc <= '0;
      else if (acc_en) acc <= acc + OUTPUT_BW'(prod);
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected classifier: streams one feature frame through per-class MAC
// lanes, adds biases and offers all class scores under a valid/ready handshake.
module fc_layer
  import fc_layer_pkg::*;
#(
  parameter int BW          = 8,
  parameter int NUM_INPUTS  = 208,
  parameter int NUM_CLASSES = 2,
  parameter int OUTPUT_BW   = 24
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [BW-1:0]                                 data_i,
  input  logic                                          valid_i,
  input  logic                                          last_i,
  output logic                                          ready_o,
  output logic [NUM_CLASSES*OUTPUT_BW-1:0]              data_o,
  output logic                                          valid_o,
  input  logic                                          ready_i,
  input  logic                                          wr_en_i,
  input  logic [addr_width(NUM_CLASSES, NUM_INPUTS)-1:0] wr_addr_i,
  input  logic [BW-1:0]                                 wr_data_i,
  output logic                                          err_o
);

  localparam int IW = idx_width(NUM_INPUTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUTS - 1);

  state_t state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          accept;
  logic          accept_q;
  logic          out_fire;
  logic          out_load;

  logic signed [BW-1:0]        weight [NUM_CLASSES][NUM_INPUTS];
  logic signed [BW-1:0]        bias   [NUM_CLASSES];
  logic signed [OUTPUT_BW-1:0] acc    [NUM_CLASSES];

  assign ready_o  = (state_q == ACCUM) && !rst_i;
  assign accept   = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;
  assign out_load = (state_q == OUT) && !valid_o;

  // NOTE: parameter storage has no reset branch; it is loaded by software and
  // leaving it out of reset keeps it a plain register file.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (int'(wr_addr_i) == weight_base(c, NUM_INPUTS) + i) weight[c][i] <= wr_data_i;
        end
        if (int'(wr_addr_i) == bias_base(NUM_CLASSES, NUM_INPUTS) + c) bias[c] <= wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_i) state_d = DRAIN1;
      DRAIN1:  state_d = DRAIN2;
      DRAIN2:  state_d = OUT;
      OUT:     if (out_fire) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q    <= '0;
      accept_q <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      accept_q <= accept;
      if (out_fire) begin
        idx_q <= '0;
      end else if (accept && idx_q != LAST_IDX) begin
        idx_q <= idx_q + IW'(1);
      end
      if (accept && ((last_i && idx_q != LAST_IDX) || (!last_i && idx_q == LAST_IDX))) begin
        err_o <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_mac
    fc_mac #(
      .BW       (BW),
      .OUTPUT_BW(OUTPUT_BW)
    ) u_mac (
      .clk   (clk_i),
      .rst   (rst_i),
      .mul_en(accept),
      .acc_en(accept_q),
      .clear (out_fire),
      .data  ($signed(data_i)),
      .weight(weight[c][idx_q]),
      .acc   (acc[c])
    );
  end

  // Scores are captured on the first OUT cycle, once the last product has landed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (out_load) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        data_o[c*OUTPUT_BW +: OUTPUT_BW] <= acc[c] + OUTPUT_BW'(bias[c]);
      end
      valid_o <= 1'b1;
    end else if (out_fire) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench: a 4-input instance for functional cases and a default-size
// instance for the arithmetic extremes, driven in lockstep from shared stimulus.
module tb_fc_layer;

  localparam int OBW = 24;
  localparam int NC  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, valid = 1'b0, last = 1'b0, ready_in = 1'b0;
  logic       wr_en_s = 1'b0, wr_en_b = 1'b0;
  logic [7:0] data = '0, wr_data = '0;
  logic [8:0] wr_addr = '0;

  logic ready_s, valid_s, err_s, ready_b, valid_b, err_b;
  logic [NC*OBW-1:0] data_s, data_b;

  int passed = 0;
  int total  = 0;

  fc_layer #(.BW(8), .NUM_INPUTS(4), .NUM_CLASSES(2), .OUTPUT_BW(24)) u_small (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(ready_s), .data_o(data_s), .valid_o(valid_s), .ready_i(ready_in),
    .wr_en_i(wr_en_s), .wr_addr_i(wr_addr[3:0]), .wr_data_i(wr_data), .err_o(err_s)
  );

  fc_layer #(.BW(8), .NUM_INPUTS(208), .NUM_CLASSES(2), .OUTPUT_BW(24)) u_big (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(ready_b), .data_o(data_b), .valid_o(valid_b), .ready_i(ready_in),
    .wr_en_i(wr_en_b), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .err_o(err_b)
  );

  task automatic write_param(input bit big, input int addr, input logic [7:0] val);
    wr_addr = 9'(addr);
    wr_data = val;
    if (big) wr_en_b = 1'b1;
    else     wr_en_s = 1'b1;
    @(negedge clk);
    wr_en_b = 1'b0;
    wr_en_s = 1'b0;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic l, input bit big);
    int n;
    n = 0;
    data = d; last = l; valid = 1'b1;
    while (((big ? ready_b : ready_s) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] vals [8], input int n, input int last_pos,
                            input int max_gap, input bit big);
    for (int k = 0; k < n; k++) begin
      if (max_gap > 0 && k > 0) repeat ($urandom_range(max_gap, 1)) @(negedge clk);
      drive_beat(vals[k], k == last_pos, big);
    end
  endtask

  task automatic wait_valid(input bit big, output int lat);
    lat = 0;
    while (((big ? valid_b : valid_s) !== 1'b1) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (valid_s !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_s); else passed++;
    total++; if (data_s !== '0) $display("FAIL reset_data: got %h expected 0", data_s); else passed++;
    total++; if (err_s !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_s); else passed++;
    total++; if (ready_s !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", ready_s); else passed++;
    rst = 1'b0;
    #1;
    total++; if (ready_s !== 1'b1) $display("FAIL reset_ready_release: got %b expected 1", ready_s); else passed++;
  endtask

  task automatic load_small();
    for (int i = 0; i < 4; i++) write_param(0, i, 8'd1);
    for (int i = 0; i < 4; i++) write_param(0, 4 + i, 8'hFF);
    write_param(0, 8, 8'd5);
    write_param(0, 9, 8'hFB);
    write_param(0, 15, 8'h55);
  endtask

  task automatic test_basic();
    logic [7:0] v [8];
    int lat;
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(v, 4, 3, 0, 0);
    wait_valid(0, lat);
    total++; if (lat !== 3) $display("FAIL basic_latency: got %0d expected 3", lat); else passed++;
    total++; if (data_s !== {24'hFFFFF1, 24'h00000F})
      $display("FAIL basic_scores: got %h expected fffff100000f", data_s); else passed++;
    total++; if (err_s !== 1'b0) $display("FAIL basic_err: got %b expected 0", err_s); else passed++;
    handshake();
  endtask

  task automatic test_bubbles();
    logic [7:0] v [8];
    int lat;
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(v, 4, 3, 3, 0);
    wait_valid(0, lat);
    total++; if (lat !== 3) $display("FAIL bubbles_latency: got %0d expected 3", lat); else passed++;
    total++; if (data_s !== {24'hFFFFF1, 24'h00000F})
      $display("FAIL bubbles_scores: got %h expected fffff100000f", data_s); else passed++;
    handshake();
  endtask

  task automatic test_backpressure();
    logic [7:0] v [8];
    logic [NC*OBW-1:0] d0;
    int lat, bad_hold, bad_ready;
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(v, 4, 3, 0, 0);
    wait_valid(0, lat);
    d0 = data_s;
    total++; if (d0 !== {24'hFFFFF1, 24'h00000F})
      $display("FAIL bp_scores: got %h expected fffff100000f", d0); else passed++;
    bad_hold = 0; bad_ready = 0;
    data = 8'h07; valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (data_s !== d0 || valid_s !== 1'b1) bad_hold++;
      if (ready_s !== 1'b0) bad_ready++;
    end
    valid = 1'b0;
    total++; if (bad_hold != 0) $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad_hold); else passed++;
    total++; if (bad_ready != 0) $display("FAIL bp_ready: %0d cycles ready high, expected 0", bad_ready); else passed++;
    handshake();
    total++; if (valid_s !== 1'b0) $display("FAIL bp_valid_drop: got %b expected 0", valid_s); else passed++;
    total++; if (ready_s !== 1'b1) $display("FAIL bp_ready_return: got %b expected 1", ready_s); else passed++;
    v = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(v, 4, 3, 0, 0);
    wait_valid(0, lat);
    total++; if (lat !== 3) $display("FAIL bp2_latency: got %0d expected 3", lat); else passed++;
    total++; if (data_s !== {24'hFFFFF7, 24'h000009})
      $display("FAIL bp2_scores: got %h expected fffff7000009", data_s); else passed++;
    total++; if (err_s !== 1'b0) $display("FAIL bp2_err: got %b expected 0", err_s); else passed++;
    handshake();
  endtask

  task automatic test_short_frame();
    logic [7:0] v [8];
    int lat;
    v = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(v, 3, 2, 0, 0);
    wait_valid(0, lat);
    total++; if (data_s !== {24'hFFFFF5, 24'h00000B})
      $display("FAIL short_scores: got %h expected fffff500000b", data_s); else passed++;
    total++; if (err_s !== 1'b1) $display("FAIL short_err: got %b expected 1", err_s); else passed++;
    handshake();
  endtask

  task automatic test_mid_reset();
    logic [7:0] v [8];
    int lat;
    drive_beat(8'd1, 1'b0, 0);
    drive_beat(8'd2, 1'b0, 0);
    rst = 1'b1;
    #1;
    total++; if (ready_s !== 1'b0) $display("FAIL midrst_ready_low: got %b expected 0", ready_s); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (valid_s !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", valid_s); else passed++;
    total++; if (err_s !== 1'b0) $display("FAIL midrst_err: got %b expected 0", err_s); else passed++;
    total++; if (ready_s !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", ready_s); else passed++;
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(v, 4, 3, 0, 0);
    wait_valid(0, lat);
    total++; if (lat !== 3) $display("FAIL midrst_latency: got %0d expected 3", lat); else passed++;
    total++; if (data_s !== {24'hFFFFF1, 24'h00000F})
      $display("FAIL midrst_scores: got %h expected fffff100000f", data_s); else passed++;
    handshake();
  endtask

  task automatic test_long_frame();
    int lat;
    drive_beat(8'd1, 1'b0, 0);
    drive_beat(8'd2, 1'b0, 0);
    drive_beat(8'd3, 1'b0, 0);
    total++; if (err_s !== 1'b0) $display("FAIL long_err_early: got %b expected 0", err_s); else passed++;
    drive_beat(8'd4, 1'b0, 0);
    total++; if (err_s !== 1'b1) $display("FAIL long_err_set: got %b expected 1", err_s); else passed++;
    drive_beat(8'd5, 1'b1, 0);
    wait_valid(0, lat);
    total++; if (data_s !== {24'hFFFFEC, 24'h000014})
      $display("FAIL long_scores: got %h expected ffffec000014", data_s); else passed++;
    handshake();
  endtask

  task automatic test_extremes();
    int lat;
    for (int a = 0; a < 416; a++) write_param(1, a, 8'h80);
    write_param(1, 416, 8'h00);
    write_param(1, 417, 8'h00);
    for (int k = 0; k < 208; k++) drive_beat(8'h80, k == 207, 1);
    wait_valid(1, lat);
    total++; if (lat !== 3) $display("FAIL ext_latency: got %0d expected 3", lat); else passed++;
    total++; if (data_b !== {24'h340000, 24'h340000})
      $display("FAIL ext_scores_bias0: got %h expected 340000340000", data_b); else passed++;
    handshake();
    write_param(1, 416, 8'h80);
    write_param(1, 417, 8'h80);
    for (int k = 0; k < 208; k++) drive_beat(8'h80, k == 207, 1);
    wait_valid(1, lat);
    total++; if (lat !== 3) $display("FAIL ext2_latency: got %0d expected 3", lat); else passed++;
    total++; if (data_b !== {24'h33FF80, 24'h33FF80})
      $display("FAIL ext_scores_bias_neg: got %h expected 33ff8033ff80", data_b); else passed++;
    handshake();
  endtask

  initial begin
    test_reset();
    load_small();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_short_frame();
    test_mid_reset();
    test_long_frame();
    test_extremes();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
    $fatal(1, "time limit reached");
  end

endmodule
